// File: rtl/shift_add_mul_arbiter.sv
// ---------------------------------------------------------------------------
// shift_add_mul_arbiter
//
// Purpose : one iterative shift-and-add multiplier engine shared by NREQ
//           requesters. A round-robin arbiter picks one requester at a time.
//           The engine retires one multiplier bit per cycle. The product goes
//           out on a single response channel tagged with the requester index.
//
// Optional: define EARLY_TERM_EN to let the engine leave BUSY as soon as the
//           remaining multiplier bits are all zero. Without it every operation
//           takes exactly N BUSY cycles.
//
// Ports   :
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NREQ]      per-requester request valid
//   req_ready  out  [NREQ]      per-requester accept, one-hot or zero, IDLE only
//   req_a      in   [NREQ*M]    multiplicands, requester i at [i*M +: M]
//   req_b      in   [NREQ*N]    multipliers,   requester i at [i*N +: N]
//   rsp_valid  out              product valid (held until rsp_ready)
//   rsp_ready  in               consumer accepts product
//   rsp_id     out  [IDW]       requester index that owns rsp_p
//   rsp_p      out  [M+N]       unsigned product A*B
//   busy       out              high whenever the engine is not IDLE
// ---------------------------------------------------------------------------
module shift_add_mul_arbiter #(
   parameter int M    = 8,
   parameter int N    = 8,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*M-1:0]   req_a,
   input  logic [NREQ*N-1:0]   req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [M+N-1:0]      rsp_p,
   output logic                busy
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(N + 1);
   localparam int PWD = M + N;

   if (IDW < PW) begin : g_bad_idw
      $error("IDW must be at least clog2(NREQ)");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [PW-1:0]     rr_ptr;
   logic [PWD-1:0]    acc;
   logic [PWD-1:0]    a_sh;
   logic [N-1:0]      b_sh;
   logic [CW-1:0]     cnt;
   logic [IDW-1:0]    id;

   // ------------------------------------------------------------------
   // Per-requester operand lanes, unpacked from the flat buses
   // ------------------------------------------------------------------
   logic [NREQ-1:0][M-1:0] a_lane;
   logic [NREQ-1:0][N-1:0] b_lane;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign a_lane[g] = req_a[g*M +: M];
      assign b_lane[g] = req_b[g*N +: N];
   end

   // ------------------------------------------------------------------
   // Round-robin pick: first valid index starting at rr_ptr, wrapping.
   // ------------------------------------------------------------------
   logic [NREQ-1:0] grant_oh;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   int              cand;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(rr_ptr) + k) % NREQ;
         if (!grant_any && req_valid[cand]) begin
            grant_any      = 1'b1;
            grant_oh[cand] = 1'b1;
            grant_idx      = PW'(cand);
         end
      end
   end

   // The pointer moves just past the winner so it has lowest priority next.
   logic [PW-1:0] rr_next;
   assign rr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

   // Grants are offered only while idle, so a handshake can only happen there.
   assign req_ready = (state == IDLE) ? grant_oh : '0;
   assign busy      = (state != IDLE);

   // ------------------------------------------------------------------
   // One shift-and-add step
   // ------------------------------------------------------------------
   logic [PWD-1:0] acc_sum;
   logic [N-1:0]   b_next;
   logic           last_step;

   assign acc_sum = b_sh[0] ? (acc + a_sh) : acc;
   assign b_next  = b_sh >> 1;

`ifdef EARLY_TERM_EN
   // Once the remaining multiplier bits are zero, later steps add nothing.
   assign last_step = (cnt == CW'(N - 1)) || (b_next == '0);
`else
   assign last_step = (cnt == CW'(N - 1));
`endif

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         acc       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         cnt       <= '0;
         id        <= '0;
         rsp_valid <= 1'b0;
         rsp_p     <= '0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // In IDLE, req_valid & req_ready is non-zero exactly when grant_any.
               if (grant_any) begin
                  a_sh   <= {{N{1'b0}}, a_lane[grant_idx]};
                  b_sh   <= b_lane[grant_idx];
                  acc    <= '0;
                  cnt    <= '0;
                  id     <= IDW'(grant_idx);
                  rr_ptr <= rr_next;
                  state  <= BUSY;
               end
            end

            BUSY: begin
               acc  <= acc_sum;
               a_sh <= a_sh << 1;
               b_sh <= b_next;
               cnt  <= cnt + CW'(1);
               if (last_step) begin
                  rsp_p     <= acc_sum;
                  rsp_id    <= id;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               // No grant in the handshake cycle: req_ready is zero outside IDLE.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mul_arbiter
//
// Self-checking bench for shift_add_mul_arbiter. Each scenario task drives
// stimulus and checks inline against a behavioural model. The model covers
// round-robin order, product = a*b, and BUSY length from the multiplier value.
// ---------------------------------------------------------------------------
module tb_shift_add_mul_arbiter;

   localparam int M    = 8;
   localparam int N    = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*M-1:0]   req_a;
   logic [NREQ*N-1:0]   req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [M+N-1:0]      rsp_p;
   logic                busy;

   shift_add_mul_arbiter #(.M(M), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct { int g; logic [NREQ-1:0] rdy; logic [NREQ-1:0] vld; int ec; } acc_t;
   typedef struct { int id; int p; int ec; } rsp_t;

   acc_t acc_log[$];
   rsp_t rsp_log[$];
   int   rise_log[$];

   int cyc = 0, busy_cnt = 0, n_chk = 0, n_fail = 0, ptr = 0;
   bit hold = 0, scramble = 0, rand_rdy = 0, prev_rv = 0;

   // ---------------- reference model ----------------
   function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
      int r = -1;
      for (int k = 0; k < NREQ; k++)
         if (r < 0 && v[(p + k) % NREQ]) r = (p + k) % NREQ;
      return r;
   endfunction

   function automatic int exp_lat(input int b);
`ifdef EARLY_TERM_EN
      int k = 0;
      for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
      return (k == 0) ? 1 : k;
`else
      return N + (b & 0);
`endif
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int e);
      logic [NREQ-1:0] v = '0;
      if (e >= 0) v[e] = 1'b1;
      return v;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic set_op(input int i, input int a, input int b);
      req_a[i*M +: M] = M'(a);
      req_b[i*N +: N] = N'(b);
   endtask

   // Observe at the falling edge, advance to 1 time unit after the rising edge.
   task automatic tick();
      int g = -1;
      bit got = 0;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!rst) begin
         if (req_ready != '0) begin
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            acc_log.push_back('{g, req_ready, req_valid, cyc + 1});
            got = 1;
         end
         if (rsp_valid && !prev_rv) rise_log.push_back(cyc);
         if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), int'(rsp_p), cyc + 1});
      end
      prev_rv = rsp_valid;
      @(posedge clk);
      cyc++;
      #1;
      if (got) begin
         if (!hold) req_valid[g] = 1'b0;
         if (scramble) begin
            req_a[g*M +: M] = M'($urandom);
            req_b[g*N +: N] = N'($urandom);
         end
      end
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic run_until(input int nrsp, input int budget, output bit to);
      int base = rsp_log.size();
      for (int i = 0; i < budget && (rsp_log.size() - base) < nrsp; i++) tick();
      to = (rsp_log.size() - base) < nrsp;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      ptr = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      tick();
      tick();
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_chk++; if (rsp_p !== '0) begin n_fail++; $display("FAIL reset_rsp_p got %0d want 0", rsp_p); end
      n_chk++; if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
      rst = 1'b0;
      ptr = 0;
      tick();
   endtask

   task automatic test_single();
      int ab = acc_log.size(), rb = rsp_log.size(), ib = rise_log.size(), bb = busy_cnt, e;
      bit to;
      set_op(0, 13, 11);
      hold = 0; scramble = 0; rand_rdy = 0; rsp_ready = 1'b1; req_valid = 4'b0001;
      run_until(1, 60, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL single_timeout got no response want 1"); end
      n_chk++; if (acc_log.size() - ab !== 1) begin n_fail++; $display("FAIL single_accepts got %0d want 1", acc_log.size() - ab); end
      if (!to && acc_log.size() > ab && rise_log.size() > ib) begin
         e = exp_grant(4'b0001, ptr);
         n_chk++; if (acc_log[ab].rdy !== onehot(e)) begin n_fail++; $display("FAIL single_ready got %b want %b", acc_log[ab].rdy, onehot(e)); end
         n_chk++; if (rise_log[ib] - acc_log[ab].ec !== exp_lat(11)) begin n_fail++; $display("FAIL single_latency got %0d want %0d", rise_log[ib] - acc_log[ab].ec, exp_lat(11)); end
         n_chk++; if (rsp_log[rb].p !== 13 * 11) begin n_fail++; $display("FAIL single_product got %0d want %0d", rsp_log[rb].p, 13 * 11); end
         n_chk++; if (rsp_log[rb].id !== e) begin n_fail++; $display("FAIL single_id got %0d want %0d", rsp_log[rb].id, e); end
         n_chk++; if (busy_cnt - bb !== exp_lat(11) + 1) begin n_fail++; $display("FAIL single_busy_cycles got %0d want %0d", busy_cnt - bb, exp_lat(11) + 1); end
         ptr = (e + 1) % NREQ;
      end
   endtask

   task automatic test_round_robin();
      int ab, rb, ib, e, pe;
      bit to;
      do_reset();
      ab = acc_log.size(); rb = rsp_log.size(); ib = rise_log.size();
      for (int i = 0; i < NREQ; i++) set_op(i, i + 2, i + 3);
      hold = 1; scramble = 0; rand_rdy = 0; rsp_ready = 1'b1; req_valid = '1;
      run_until(5, 200, to);
      req_valid = '0;
      hold = 0;
      n_chk++; if (to) begin n_fail++; $display("FAIL rr_timeout got %0d responses want 5", rsp_log.size() - rb); end
      if (!to && acc_log.size() - ab >= 5 && rise_log.size() - ib >= 5) begin
         pe = -1;
         for (int j = 0; j < 5; j++) begin
            e = exp_grant(acc_log[ab + j].vld, ptr);
            n_chk++; if (acc_log[ab + j].g !== e) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", j, acc_log[ab + j].g, e); end
            n_chk++; if (rsp_log[rb + j].p !== (e + 2) * (e + 3)) begin n_fail++; $display("FAIL rr_product[%0d] got %0d want %0d", j, rsp_log[rb + j].p, (e + 2) * (e + 3)); end
            n_chk++; if (rise_log[ib + j] - acc_log[ab + j].ec !== exp_lat(e + 3)) begin n_fail++; $display("FAIL rr_latency[%0d] got %0d want %0d", j, rise_log[ib + j] - acc_log[ab + j].ec, exp_lat(e + 3)); end
            if (j > 0) begin
               n_chk++;
               if (acc_log[ab + j].ec - acc_log[ab + j - 1].ec !== exp_lat(pe + 3) + 2) begin
                  n_fail++; $display("FAIL rr_spacing[%0d] got %0d want %0d", j, acc_log[ab + j].ec - acc_log[ab + j - 1].ec, exp_lat(pe + 3) + 2);
               end
            end
            pe = e;
            ptr = (e + 1) % NREQ;
         end
      end
   endtask

   task automatic test_operands();
      int da[6] = '{255, 0, 200, 13, 77, 91};
      int db[6] = '{255, 200, 0, 128, 3, 1};
      int ab, rb, ib, e, ea, eb;
      logic [NREQ-1:0] mask;
      bit to;
      for (int j = 0; j < 26; j++) begin
         if (j < 6) begin
            mask = onehot(j % NREQ);
            set_op(j % NREQ, da[j], db[j]);
            scramble = 0; rand_rdy = 0; rsp_ready = 1'b1;
         end else begin
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
            mask = NREQ'($urandom_range(1, 15));
            scramble = 1; rand_rdy = 1; rsp_ready = 1'($urandom_range(0, 1));
         end
         e  = exp_grant(mask, ptr);
         ea = int'(req_a[e*M +: M]);
         eb = int'(req_b[e*N +: N]);
         ab = acc_log.size(); rb = rsp_log.size(); ib = rise_log.size();
         req_valid = mask;
         run_until(1, 200, to);
         req_valid = '0; scramble = 0; rand_rdy = 0; rsp_ready = 1'b1;
         n_chk++; if (to) begin n_fail++; $display("FAIL op[%0d]_timeout got no response want 1", j); end
         if (!to && acc_log.size() > ab && rise_log.size() > ib) begin
            n_chk++; if (acc_log[ab].g !== e) begin n_fail++; $display("FAIL op[%0d]_grant got %0d want %0d", j, acc_log[ab].g, e); end
            n_chk++; if (rsp_log[rb].p !== ea * eb) begin n_fail++; $display("FAIL op[%0d]_product a=%0d b=%0d got %0d want %0d", j, ea, eb, rsp_log[rb].p, ea * eb); end
            n_chk++; if (rsp_log[rb].id !== e) begin n_fail++; $display("FAIL op[%0d]_id got %0d want %0d", j, rsp_log[rb].id, e); end
            n_chk++; if (rise_log[ib] - acc_log[ab].ec !== exp_lat(eb)) begin n_fail++; $display("FAIL op[%0d]_latency b=%0d got %0d want %0d", j, eb, rise_log[ib] - acc_log[ab].ec, exp_lat(eb)); end
         end
         ptr = (e + 1) % NREQ;
      end
   endtask

   task automatic test_backpressure();
      int ab, rb, ib;
      bit to;
      do_reset();
      ab = acc_log.size(); rb = rsp_log.size(); ib = rise_log.size();
      set_op(0, 5, 6);
      set_op(2, 7, 9);
      hold = 0; scramble = 0; rand_rdy = 0; rsp_ready = 1'b0; req_valid = 4'b0101;
      for (int i = 0; i < 50 && rise_log.size() == ib; i++) tick();
      n_chk++; if (rise_log.size() == ib) begin n_fail++; $display("FAIL bp_timeout got no rsp_valid want 1"); end
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
         n_chk++; if (rsp_p !== (M+N)'(30)) begin n_fail++; $display("FAIL bp_product[%0d] got %0d want 30", i, rsp_p); end
         n_chk++; if (rsp_id !== IDW'(0)) begin n_fail++; $display("FAIL bp_id[%0d] got %0d want 0", i, rsp_id); end
         n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
      end
      rsp_ready = 1'b1;
      run_until(2, 80, to);
      req_valid = '0;
      n_chk++; if (to) begin n_fail++; $display("FAIL bp_second_timeout got %0d responses want 2", rsp_log.size() - rb); end
      if (!to && acc_log.size() - ab >= 2) begin
         n_chk++; if (acc_log[ab + 1].g !== exp_grant(acc_log[ab + 1].vld, 1)) begin n_fail++; $display("FAIL bp_second_grant got %0d want 2", acc_log[ab + 1].g); end
         n_chk++; if (acc_log[ab + 1].ec !== rsp_log[rb].ec + 1) begin n_fail++; $display("FAIL bp_accept_after_rsp got edge %0d want %0d", acc_log[ab + 1].ec, rsp_log[rb].ec + 1); end
         n_chk++; if (rsp_log[rb + 1].p !== 7 * 9) begin n_fail++; $display("FAIL bp_second_product got %0d want %0d", rsp_log[rb + 1].p, 7 * 9); end
         n_chk++; if (rsp_log[rb + 1].id !== 2) begin n_fail++; $display("FAIL bp_second_id got %0d want 2", rsp_log[rb + 1].id); end
      end
      ptr = 3;
   endtask

   task automatic test_reset_midop();
      int ab = acc_log.size(), rb = rsp_log.size(), ib = rise_log.size(), e;
      bit to;
`ifdef EARLY_TERM_EN
      set_op(2, 9, 8'h87);
`else
      set_op(2, 9, 7);
`endif
      hold = 0; scramble = 0; rand_rdy = 0; rsp_ready = 1'b0; req_valid = 4'b0100;
      for (int i = 0; i < 20 && acc_log.size() == ab; i++) tick();
      n_chk++; if (acc_log.size() == ab) begin n_fail++; $display("FAIL midrst_accept_timeout got no accept want 1"); end
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid got %b want 0", rsp_valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_chk++; if (rsp_p !== '0) begin n_fail++; $display("FAIL midrst_rsp_p got %0d want 0", rsp_p); end
      n_chk++; if (rsp_id !== '0) begin n_fail++; $display("FAIL midrst_rsp_id got %0d want 0", rsp_id); end
      n_chk++; if (rise_log.size() !== ib) begin n_fail++; $display("FAIL midrst_no_response got %0d rises want 0", rise_log.size() - ib); end
      tick(); tick();
      set_op(2, 3, 4);
      set_op(3, 5, 6);
      req_valid = 4'b1100; rsp_ready = 1'b1;
      rst = 1'b0;
      ptr = 0;
      ab = acc_log.size();
      run_until(1, 60, to);
      req_valid = '0;
      e = exp_grant(4'b1100, ptr);
      n_chk++; if (to) begin n_fail++; $display("FAIL midrst_after_timeout got no response want 1"); end
      if (!to && acc_log.size() > ab) begin
         n_chk++; if (acc_log[ab].g !== e) begin n_fail++; $display("FAIL midrst_first_grant got %0d want %0d", acc_log[ab].g, e); end
         n_chk++; if (rsp_log[rb].p !== 3 * 4) begin n_fail++; $display("FAIL midrst_first_product got %0d want %0d", rsp_log[rb].p, 3 * 4); end
         n_chk++; if (rsp_log[rb].id !== e) begin n_fail++; $display("FAIL midrst_first_id got %0d want %0d", rsp_log[rb].id, e); end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_operands();
      test_backpressure();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_add_mul_arbiter.md
Name: shift_add_mul_arbiter

Overview:
- Shares one iterative shift-and-add multiplier engine between NREQ requesters.
- Round-robin arbitration; valid/ready handshake per requester; single response channel tagged with requester ID.
- Engine processes one multiplier bit per cycle. Sits between client blocks and the arithmetic datapath as its sequencer.

Parameters:
M, 8, multiplicand width (bits)
N, 8, multiplier width (bits); also the number of BUSY cycles per operation
NREQ, 4, number of requesters (2..8)
IDW, 2, response ID width; must be >= clog2(NREQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_a  input  NREQ*M  flattened multiplicands; requester i occupies bits [i*M +: M]
req_b  input  NREQ*N  flattened multipliers; requester i occupies bits [i*N +: N]
rsp_valid  output  1  product valid
rsp_ready  input  1  consumer accepts product
rsp_id  output  IDW  index of the requester that owns rsp_p
rsp_p  output  M+N  unsigned product A*B
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0, internal acc/a_sh/b_sh/cnt=0. Any in-flight operation is discarded; no response is issued for it.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_ready is combinational. It is one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ. It is zero when no requester is valid, and zero in every state other than IDLE.
  - Handshake at a clock edge with req_valid[g] & req_ready[g]: capture a_sh = zero-extended req_a[g] (M+N bits), b_sh = req_b[g], acc=0, cnt=0, id=g, rr_ptr=(g+1) mod NREQ, then go to BUSY.
- BUSY, one step per cycle:
  - If b_sh[0], acc = acc + a_sh; the sum is M+N bits and cannot overflow.
  - Then a_sh <<= 1, b_sh >>= 1, cnt++.
  - After the step where cnt reaches N-1, go to DONE and load rsp_p=final acc, rsp_id=id, rsp_valid=1.
- DONE:
  - rsp_valid held; rsp_p and rsp_id stable until the rsp_ready handshake.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE. No new request is accepted in that same cycle.
- Latency: request accepted at edge E; rsp_valid is high after edge E+N. Minimum spacing between accepts is N+2 cycles when rsp_ready is held high.
- Fairness: a continuously asserting requester waits at most NREQ-1 operations.
- Request signals are sampled only at the accept edge. Later changes to req_a/req_b do not affect the operation in flight.
- A requester may drop req_valid at any time before its accept without penalty.
- Operand 0 in either position: still N BUSY cycles, result 0 (except under EARLY_TERM_EN, below).
- Max operands (all ones): P = (2^M-1)*(2^N-1), exact.
- rsp_ready while rsp_valid=0: ignored.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined:
  - BUSY also exits to DONE after any step that leaves b_sh==0 (shifted value).
  - A multiplier of 0 or 1 takes one BUSY cycle. A multiplier whose top set bit is k takes k+1 BUSY cycles.
  - Result is identical; latency varies with B. Arbitration and handshakes are unchanged.
- Undefined: fixed N BUSY cycles, as above.

Test Plan:
- Reset, then req_valid=0001, A0=13, B0=11 -> req_ready=0001 for one cycle; rsp_valid high N=8 cycles after accept; rsp_p=143, rsp_id=0; busy high throughout.
- All four requesters valid continuously (Ai=i+2, Bi=i+3), rsp_ready=1 -> grant order 0,1,2,3,0; products 6, 12, 20, 30; accepts spaced exactly 10 cycles apart.
- A0=255, B0=255 -> rsp_p=65025. A0=0, B0=200 -> rsp_p=0. A0=200, B0=0 -> rsp_p=0 after 8 BUSY cycles (1 BUSY cycle with EARLY_TERM_EN).
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid rises -> rsp_valid, rsp_p, rsp_id stable; req_ready=0 throughout; request 2 is accepted only after the response handshake.
- Assert rst at BUSY step 4 of A=9, B=7 -> outputs return to reset values immediately; no response emitted; after release the first grant goes to the lowest valid index (rr_ptr=0).
- EARLY_TERM_EN: B=0x80 takes 8 BUSY cycles, B=0x03 takes 2, B=0x01 takes 1 -> correct products for each.
